// File: rtl/remote_comm.sv
// Remote command link: serializes a 16-bit command as two 8N1 bytes on TX
// (high byte first, back to back) and independently receives 8N1 response
// bytes on RX.
//
// TX FSM
//   state | meaning
//   IDLE  | line idle high, waiting for send_cmd
//   HIGH  | serializing cmd_hold[15:8]
//   LOW   | serializing cmd_hold[7:0]
//
// RX FSM
//   state   | meaning
//   R_IDLE  | waiting for a falling edge on the synchronized line
//   R_START | counting to mid start bit, rejects glitches
//   R_DATA  | sampling 8 data bits, LSB first
//   R_STOP  | sampling stop bit, loads resp when framed correctly
module remote_comm #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_cmd,
    input  logic [15:0] cmd,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    tx_state_t   tx_state;
    logic [15:0] cmd_hold;
    logic [15:0] tx_baud;
    logic [3:0]  tx_bit;

    rx_state_t   rx_state;
    logic [1:0]  rx_sync;
    logic        rx_prev;
    logic        rx_s;
    logic [15:0] rx_baud;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_set;
    logic        accept;

    assign rx_s   = rx_sync[1];
    assign accept = (tx_state == IDLE) && send_cmd;
    assign rx_set = (rx_state == R_STOP) && (rx_baud == 16'd0) && rx_s;

    // TX FSM: bit index 0 is the start bit, 1..8 data, 9 stop; TX is
    // registered and loaded with the value of the bit being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            cmd_hold <= '0;
            tx_baud  <= '0;
            tx_bit   <= '0;
            TX       <= 1'b1;
            busy     <= 1'b0;
            cmd_sent <= 1'b0;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (send_cmd) begin
                        cmd_hold <= cmd;
                        tx_baud  <= BAUD_LAST;
                        tx_bit   <= '0;
                        TX       <= 1'b0;
                        busy     <= 1'b1;
                        cmd_sent <= 1'b0;
                        tx_state <= HIGH;
                    end
                end
                HIGH, LOW: begin
                    if (tx_baud != 16'd0) begin
                        tx_baud <= tx_baud - 16'd1;
                    end else if (tx_bit == 4'd9) begin
                        tx_bit <= '0;
                        if (tx_state == HIGH) begin
                            tx_baud  <= BAUD_LAST;
                            TX       <= 1'b0;
                            tx_state <= LOW;
                        end else begin
                            TX       <= 1'b1;
                            busy     <= 1'b0;
                            cmd_sent <= 1'b1;
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_baud <= BAUD_LAST;
                        tx_bit  <= tx_bit + 4'd1;
                        if (tx_bit == 4'd8)
                            TX <= 1'b1;
                        else
                            TX <= cmd_hold[{tx_state == HIGH, tx_bit[2:0]}];
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], RX};
            rx_prev <= rx_sync[1];
        end
    end

    // RX FSM: samples mid-bit, counting from the detected falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            resp     <= '0;
        end else begin
            case (rx_state)
                R_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_baud  <= HALF_LAST;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_baud != 16'd0) begin
                        rx_baud <= rx_baud - 16'd1;
                    end else if (rx_s) begin
                        rx_state <= R_IDLE;
                    end else begin
                        rx_baud  <= BAUD_LAST;
                        rx_bit   <= '0;
                        rx_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rx_baud != 16'd0) begin
                        rx_baud <= rx_baud - 16'd1;
                    end else begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_baud  <= BAUD_LAST;
                        if (rx_bit == 4'd7) begin
                            rx_bit   <= '0;
                            rx_state <= R_STOP;
                        end else begin
                            rx_bit <= rx_bit + 4'd1;
                        end
                    end
                end
                R_STOP: begin
                    if (rx_baud != 16'd0) begin
                        rx_baud <= rx_baud - 16'd1;
                    end else begin
                        if (rx_s)
                            resp <= rx_shift;
                        rx_state <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

    // Response flag: a received byte sets it and wins over any clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            resp_rdy <= 1'b0;
        else if (rx_set)
            resp_rdy <= 1'b1;
        else if (clr_resp_rdy || accept)
            resp_rdy <= 1'b0;
    end

endmodule
